mux_sc_arb: RTL and testbench
=============================

// Module: mux_sc_arb
// PURPOSE
//  Two-input stream arbiter that sits directly upstream of the scalable 2:1 mux.
//  Picks A or B per transfer (round-robin by default) and drives the mux SEL.
//  Registers the selected word in a single-entry output stage with valid/ready flow control.
//  Data path is SIZE bits wide, matching the mux it feeds.
// PARAMETERS
//  SIZE  1  data width in bits of A, B and OUT
// PORTS
//  CLK        in   1     clock; all state updates on rising edge
//  RST        in   1     reset, synchronous, active-high
//  A          in   SIZE  source-A data
//  A_VALID    in   1     A holds a word this cycle
//  A_READY    out  1     A word is consumed this cycle
//  B          in   SIZE  source-B data
//  B_VALID    in   1     B holds a word this cycle
//  B_READY    out  1     B word is consumed this cycle
//  SEL        out  1     registered select: 0 = A, 1 = B, source of the word in OUT
//  OUT        out  SIZE  registered selected data
//  OUT_VALID  out  1     OUT holds a word
//  OUT_READY  in   1     downstream consumes OUT this cycle
// BEHAVIOUR
//  - Reset (RST=1 at edge): OUT=0, OUT_VALID=0, SEL=0, LAST=1 (so A wins the first tie), state EMPTY.
//  - Handshake rules:
//    - Transfer on input X when X_VALID && X_READY.
//    - Transfer on output when OUT_VALID && OUT_READY.
//    - A source holding VALID must keep its data stable until READY.
//  - ACCEPT = !OUT_VALID || OUT_READY. Drain and refill in the same cycle is allowed,
//    giving full throughput of one word per cycle.
//  - Grant (combinational, evaluated when ACCEPT):
//    - Only A_VALID: grant A.
//    - Only B_VALID: grant B.
//    - Both valid: grant the source != LAST.
//    - Neither valid: no grant.
//  - Ready outputs: A_READY = ACCEPT && grant==A; B_READY = ACCEPT && grant==B.
//    They are never both 1 and depend only on VALIDs, OUT_READY and state.
//  - On a grant: OUT <= granted data, SEL <= granted id, LAST <= granted id, OUT_VALID <= 1.
//  - On output transfer with no grant: OUT_VALID <= 0. OUT and SEL hold their last values.
//  - Hold: when OUT_VALID && !OUT_READY, OUT, SEL and LAST are frozen and both READYs are 0.
//  - States:
//    - EMPTY (OUT_VALID=0) -> FULL on grant.
//    - FULL -> EMPTY on drain without grant.
//    - FULL -> FULL on drain with grant, or on stall.
//  - Latency: input word appears on OUT one cycle after its transfer edge.
//  - RST mid-operation: the held word is discarded, no READY is asserted that cycle,
//    and the reset values above apply on the next cycle.
//  - SEL changes only on a grant edge. Between transfers SEL always names the source of OUT.
// CONFIGURATION
//  MUX_SC_ARB_PRIO_EN
//    - Defined: fixed priority, A always wins a tie and LAST is not used for grant.
//    - Undefined (default): round-robin as above.
//    - Reset values and ports are identical in both builds.
// TESTING
//  1. RST=1 for 2 cycles, then RST=0 with no VALIDs
//     -> OUT_VALID=0, SEL=0, OUT=0, A_READY=B_READY=0.
//  2. SIZE=8, A_VALID=1 A=8'h5A, B_VALID=0, OUT_READY=1
//     -> A_READY=1; next cycle OUT=8'h5A, SEL=0, OUT_VALID=1.
//  3. Both VALID held 4 cycles, OUT_READY=1
//     -> grants A,B,A,B and SEL 0,1,0,1; with MUX_SC_ARB_PRIO_EN grants A,A,A,A.
//  4. OUT_VALID=1 with OUT_READY=0 for 3 cycles, both VALID
//     -> READYs 0, OUT/SEL stable; on OUT_READY=1 a new word is loaded in the same cycle.
//  5. Only B_VALID, B=8'hC3, OUT_READY=1 every cycle
//     -> OUT=8'hC3 and SEL=1 every cycle, OUT_VALID stays 1.
//  6. RST=1 while OUT_VALID=1 and both VALID
//     -> A_READY=B_READY=0 that cycle; next cycle OUT_VALID=0, then A granted first.

Source files
------------

// File: rtl/mux_sc_arb.sv
`default_nettype none
// ============================================================================
// Module      : mux_sc_arb
// Description : Two-input valid/ready arbiter feeding the scalable 2:1 mux.
//               The single-entry registered output carries the winning word
//               and its select. Round-robin by default; defining
//               MUX_SC_ARB_PRIO_EN selects fixed A-first priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_sc_arb #(
   parameter int SIZE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] a,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [SIZE-1:0] b,
   input  logic            b_valid,
   output logic            b_ready,
   output logic            sel,
   output logic [SIZE-1:0] out,
   output logic            out_valid,
   input  logic            out_ready
);

   localparam logic [0:0] c_st_empty = 1'b0;
   localparam logic [0:0] c_st_full  = 1'b1;

   logic [0:0]      r_state;
   logic            r_sel;
   logic            r_last;
   logic [SIZE-1:0] r_out;

   logic            w_accept;
   logic            w_grant;
   logic            w_pick_b;

   // Reset suppresses both readies so no word is lost during the reset cycle.
   assign w_accept = !rst && ((r_state == c_st_empty) || out_ready);
   assign w_grant  = w_accept && (a_valid || b_valid);

`ifdef MUX_SC_ARB_PRIO_EN
   assign w_pick_b = b_valid && !a_valid;
`else
   // On a tie B wins only when A was the most recent grant.
   assign w_pick_b = b_valid && (!a_valid || !r_last);
`endif

   assign a_ready   = w_grant && !w_pick_b;
   assign b_ready   = w_grant &&  w_pick_b;
   assign sel       = r_sel;
   assign out       = r_out;
   assign out_valid = (r_state == c_st_full);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_empty;
         r_out   <= '0;
         r_sel   <= 1'b0;
         r_last  <= 1'b1;
      end else if (w_grant) begin
         r_state <= c_st_full;
         r_out   <= w_pick_b ? b : a;
         r_sel   <= w_pick_b;
         r_last  <= w_pick_b;
      end else if ((r_state == c_st_full) && out_ready) begin
         r_state <= c_st_empty;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux_sc_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_sc_arb
// Description : Self-checking bench for mux_sc_arb (SIZE=8), directed
//               scenarios plus randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sc_arb;

   localparam int SIZE = 8;
`ifdef MUX_SC_ARB_PRIO_EN
   localparam bit c_prio = 1'b1;
`else
   localparam bit c_prio = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [SIZE-1:0] a;
   logic            a_valid;
   logic            a_ready;
   logic [SIZE-1:0] b;
   logic            b_valid;
   logic            b_ready;
   logic            sel;
   logic [SIZE-1:0] out;
   logic            out_valid;
   logic            out_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_sc_arb #(.SIZE(SIZE)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .b         (b),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic set_in(input logic av, input logic [SIZE-1:0] ad,
                         input logic bv, input logic [SIZE-1:0] bd,
                         input logic ordy);
      a_valid   = av;
      a         = ad;
      b_valid   = bv;
      b         = bd;
      out_ready = ordy;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      set_in(1'b0, '0, 1'b0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      #2;
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %0b expected 0", a_ready); end
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %0b expected 0", b_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %0b expected 0", sel); end
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %0h expected 00", out); end
   endtask

   task automatic test_single_a;
      do_reset();
      set_in(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
      #2;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready: got %0b expected 1", a_ready); end
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL single_b_ready: got %0b expected 0", b_ready); end
      @(posedge clk); #1;
      set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      checks++; if (out !== 8'h5A) begin errors++; $display("FAIL single_out: got %0h expected 5a", out); end
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL single_sel: got %0b expected 0", sel); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid: got %0b expected 1", out_valid); end
   endtask

   task automatic test_round_robin;
      logic exp_b;
      do_reset();
      set_in(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      for (int i = 0; i < 4; i++) begin
         exp_b = c_prio ? 1'b0 : logic'(i % 2);
         #2;
         checks++; if (a_ready !== !exp_b) begin errors++; $display("FAIL rr_a_ready[%0d]: got %0b expected %0b", i, a_ready, !exp_b); end
         checks++; if (b_ready !== exp_b) begin errors++; $display("FAIL rr_b_ready[%0d]: got %0b expected %0b", i, b_ready, exp_b); end
         @(posedge clk); #1;
         checks++; if (sel !== exp_b) begin errors++; $display("FAIL rr_sel[%0d]: got %0b expected %0b", i, sel, exp_b); end
         checks++; if (out !== (exp_b ? 8'h22 : 8'h11)) begin errors++; $display("FAIL rr_out[%0d]: got %0h expected %0h", i, out, exp_b ? 8'h22 : 8'h11); end
      end
   endtask

   task automatic test_stall;
      logic exp_b;
      do_reset();
      set_in(1'b1, 8'h33, 1'b1, 8'h44, 1'b1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL stall_readies[%0d]: got %b expected 00", i, {a_ready, b_ready}); end
         @(posedge clk); #1;
         checks++; if ({out_valid, sel, out} !== {1'b1, 1'b0, 8'h33}) begin errors++; $display("FAIL stall_hold[%0d]: got %0b/%0b/%0h expected 1/0/33", i, out_valid, sel, out); end
      end
      out_ready = 1'b1;
      exp_b = !c_prio;
      #2;
      checks++; if (b_ready !== exp_b) begin errors++; $display("FAIL stall_release_b_ready: got %0b expected %0b", b_ready, exp_b); end
      @(posedge clk); #1;
      checks++; if (out !== (exp_b ? 8'h44 : 8'h33)) begin errors++; $display("FAIL stall_release_out: got %0h expected %0h", out, exp_b ? 8'h44 : 8'h33); end
      checks++; if (sel !== exp_b) begin errors++; $display("FAIL stall_release_sel: got %0b expected %0b", sel, exp_b); end
   endtask

   task automatic test_only_b;
      do_reset();
      set_in(1'b0, 8'h00, 1'b1, 8'hC3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #2;
         checks++; if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL only_b_readies[%0d]: got %b expected 01", i, {a_ready, b_ready}); end
         @(posedge clk); #1;
         checks++; if ({out_valid, sel, out} !== {1'b1, 1'b1, 8'hC3}) begin errors++; $display("FAIL only_b_out[%0d]: got %0b/%0b/%0h expected 1/1/c3", i, out_valid, sel, out); end
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      set_in(1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      #2;
      checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL midrst_readies: got %b expected 00", {a_ready, b_ready}); end
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if ({out_valid, sel, out} !== {1'b0, 1'b0, 8'h00}) begin errors++; $display("FAIL midrst_state: got %0b/%0b/%0h expected 0/0/00", out_valid, sel, out); end
      #1;
      checks++; if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL midrst_first_grant: got %b expected 10", {a_ready, b_ready}); end
      @(posedge clk); #1;
      checks++; if ({out_valid, sel, out} !== {1'b1, 1'b0, 8'h55}) begin errors++; $display("FAIL midrst_first_word: got %0b/%0b/%0h expected 1/0/55", out_valid, sel, out); end
   endtask

   // Reference model: a one-word buffer with the id of the last winner.
   task automatic test_random;
      logic            m_valid, m_sel, m_last;
      logic [SIZE-1:0] m_out;
      logic            av, bv, ga, gb, accept;
      logic [SIZE-1:0] ad, bd;
      do_reset();
      m_valid = 1'b0; m_sel = 1'b0; m_last = 1'b1; m_out = '0;
      av = 1'b0; bv = 1'b0; ad = '0; bd = '0;
      ga = 1'b0; gb = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!av || ga) begin av = ($urandom_range(0, 2) != 0); ad = SIZE'($urandom); end
         if (!bv || gb) begin bv = ($urandom_range(0, 2) != 0); bd = SIZE'($urandom); end
         set_in(av, ad, bv, bd, $urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 39) == 0);
         accept = !rst && (!m_valid || out_ready);
         ga = accept && av && (!bv || c_prio || m_last);
         gb = accept && bv && !ga;
         #2;
         checks++; if ({a_ready, b_ready} !== {ga, gb}) begin errors++; $display("FAIL rand_readies[%0d]: got %b expected %b", n, {a_ready, b_ready}, {ga, gb}); end
         @(posedge clk); #1;
         if (rst) begin
            m_valid = 1'b0; m_sel = 1'b0; m_last = 1'b1; m_out = '0;
            ga = 1'b0; gb = 1'b0;
         end else if (ga || gb) begin
            m_valid = 1'b1; m_sel = gb; m_last = gb; m_out = gb ? bd : ad;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         rst = 1'b0;
         checks++; if ({out_valid, sel, out} !== {m_valid, m_sel, m_out}) begin errors++; $display("FAIL rand_out[%0d]: got %0b/%0b/%0h expected %0b/%0b/%0h", n, out_valid, sel, out, m_valid, m_sel, m_out); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_a();
      test_round_robin();
      test_stall();
      test_only_b();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
